// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the execute-stage divide controller: FSM encoding
// and default sizing.
package div_ctrl_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_ITER   = DIV_DATA_W;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_ctrl_step.sv
// One radix-2 restoring division step: shift {rem,quot} left by one, then
// subtract the divisor from the remainder when it fits.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W-1:0] rq,
  input  logic [DATA_W-1:0]   divisor,
  output logic [2*DATA_W-1:0] rq_next
);

  // The shifted remainder needs one extra bit; the borrow out of the
  // subtraction then doubles as the compare result.
  logic [DATA_W:0] trial;
  logic [DATA_W:0] diff;
  logic            fits;

  assign trial   = rq[2*DATA_W-1:DATA_W-1];
  assign diff    = trial - {1'b0, divisor};
  assign fits    = ~diff[DATA_W];
  assign rq_next = {(fits ? diff[DATA_W-1:0] : trial[DATA_W-1:0]),
                    rq[DATA_W-2:0], fits};

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer for the E stage: latches magnitudes, runs
// DATA_W restoring steps, sign-corrects into {HI,LO} and stalls F/D/E meanwhile.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                signed_div,
  input  logic [DATA_W-1:0]   opdata1,
  input  logic [DATA_W-1:0]   opdata2,
  input  logic                annul,
  output logic [2*DATA_W-1:0] result,
  output logic                ready,
  output logic                stall_div
);

  localparam int                CNT_W  = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST   = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] ZERO_Q = '1;

  div_state_e          state;
  logic [CNT_W-1:0]    counter;
  logic [2*DATA_W-1:0] rq;
  logic [DATA_W-1:0]   divisor;
  logic                neg_q;
  logic                neg_r;

  logic                a_neg;
  logic                b_neg;
  logic [DATA_W-1:0]   abs_a;
  logic [DATA_W-1:0]   abs_b;
  logic [2*DATA_W-1:0] step_rq;
  logic [DATA_W-1:0]   q_fin;
  logic [DATA_W-1:0]   r_fin;

  assign a_neg = signed_div & opdata1[DATA_W-1];
  assign b_neg = signed_div & opdata2[DATA_W-1];
  assign abs_a = a_neg ? -opdata1 : opdata1;
  assign abs_b = b_neg ? -opdata2 : opdata2;

  div_step #(.DATA_W(DATA_W)) u_step (
    .rq      (rq),
    .divisor (divisor),
    .rq_next (step_rq)
  );

  // Negation wraps at DATA_W bits, so 0x80000000 / -1 yields 0x80000000.
  assign q_fin = neg_q ? -step_rq[DATA_W-1:0] : step_rq[DATA_W-1:0];
  assign r_fin = neg_r ? -step_rq[2*DATA_W-1:DATA_W] : step_rq[2*DATA_W-1:DATA_W];

  // Low in DONE so E advances and captures result at the end of that cycle.
  assign stall_div = ~annul & (((state == DIV_IDLE) & start) | (state == DIV_BUSY));

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make ordering change behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= DIV_IDLE;
      counter <= '0;
      rq      <= '0;
      divisor <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      result  <= '0;
      ready   <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (annul) begin
        state   <= DIV_IDLE;
        counter <= '0;
      end else begin
        case (state)
          DIV_IDLE: begin
            if (start) begin
              rq      <= {{DATA_W{1'b0}}, abs_a};
              divisor <= abs_b;
              neg_q   <= a_neg ^ b_neg;
              neg_r   <= a_neg;
              counter <= '0;
              if (opdata2 == '0) begin
                state  <= DIV_DONE;
                result <= {opdata1, ZERO_Q};
                ready  <= 1'b1;
              end else begin
                state <= DIV_BUSY;
              end
            end
          end
          DIV_BUSY: begin
            rq      <= step_rq;
            counter <= counter + 1'b1;
            if (counter == LAST) begin
              state  <= DIV_DONE;
              result <= {r_fin, q_fin};
              ready  <= 1'b1;
            end
          end
          // The instruction that launched this divide is still in E.
          DIV_DONE: state <= DIV_IDLE;
          default:  state <= DIV_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Multi-cycle radix-2 restoring divider controller for the MIPS 5-stage pipeline; it sequences the execute-stage divide datapath for DIV and DIVU.
- It latches operands when a divide enters E, iterates once per cycle, and returns {HI,LO} to the E/M boundary.
- It drives stall_div, which the hazard unit consumes as stall_divE to freeze F/D/E.
- It aborts on an exception flush.

Parameters:
- DATA_W, 32, operand width; iteration count equals DATA_W.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  E-stage instruction is DIV/DIVU; held high while that instruction stays in E
- signed_div  input  1  1=DIV (signed), 0=DIVU
- opdata1  input  DATA_W  dividend (forwarded rs value)
- opdata2  input  DATA_W  divisor (forwarded rt value)
- annul  input  1  exception flush (flush_except); aborts any operation
- result  output  2*DATA_W  {remainder→HI, quotient→LO}
- ready  output  1  result valid this cycle
- stall_div  output  1  pipeline stall request while a divide is pending

Behaviour:
- Reset: state=IDLE, counter=0, result=0, ready=0, stall_div=0, internal dividend/divisor/partial remainder regs=0.
- States: IDLE, BUSY, DIVZ_DONE is not separate; the states are IDLE, BUSY, DONE.
- IDLE:
  - start=1 & annul=0: latch |opdata1| and |opdata2| (abs only if signed_div), latch sign flags, counter=0.
  - If opdata2≠0, go to BUSY. If opdata2==0, go to DONE.
- BUSY:
  - One restoring step per cycle: shift {rem,quot} left 1; if rem ≥ divisor, subtract and set quot LSB.
  - counter increments. After step DATA_W (counter==DATA_W-1), go to DONE.
- DONE:
  - ready=1; result register holds the sign-corrected value.
  - The next state is IDLE unconditionally. start is ignored in DONE, because the same instruction is still in E.
- Latency:
  - Start seen at cycle 0 → BUSY cycles 1..DATA_W → DONE at cycle DATA_W+1 (33 for DATA_W=32).
  - Divide-by-zero: DONE at cycle 1.
- stall_div (combinational):
  - 1 when (IDLE & start & ~annul) or BUSY.
  - 0 in DONE, so E advances at the end of the DONE cycle and captures result.
  - Forced 0 whenever annul=1.
- ready is 1 only in DONE and is cleared every other cycle.
- result is written only on the BUSY→DONE or IDLE→DONE transition. It holds its value otherwise, including through an annul.
- Sign rules (signed_div=1):
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - Negation is two's complement at DATA_W bits, wrapping, so 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0.
- Divide-by-zero: result = {opdata1 as latched raw, all-ones}, with no sign correction; no exception is raised.
- annul in any state: next state=IDLE, counter=0, ready=0 next cycle. An annul in the IDLE start cycle prevents the launch.
- Back-to-back divides: DONE→IDLE, then a new start is accepted in IDLE the following cycle, giving 1 non-stalled cycle between operations.
- rst overrides annul and all other inputs, mid-operation included.

Decomposition:
- Shared package/header (defines.vh):
  - state encodings DIV_IDLE/DIV_BUSY/DIV_DONE (2 bits)
  - DIV_ITER = DATA_W
  - DIV_BY_ZERO_Q = all-ones constant
- Sub-module div_step (combinational):
  - one shift/compare/subtract step
  - inputs {rem,quot}, divisor; output next {rem,quot}
  - instantiated once inside div_ctrl.

Test Plan:
- DIVU 100/7: start=1 held → stall_div=1 for cycles 0..32, ready=1 at cycle 33 with result={0x00000002,0x0000000E}, stall_div=0 at cycle 33.
- DIV -7/2 (0xFFFFFFF9, 0x00000002) → result={0xFFFFFFFF,0xFFFFFFFD}. DIV 7/-2 → {0x00000001,0xFFFFFFFD}.
- DIV 0x80000000/0xFFFFFFFF → result={0x00000000,0x80000000}, no hang, ready at cycle 33.
- DIVU 5/0 → ready at cycle 1, result={0x00000005,0xFFFFFFFF}, stall_div high only in cycle 0.
- annul pulsed at cycle 10 of a DIVU → stall_div=0 that cycle, IDLE next cycle, ready never asserted. The old result is unchanged, and a new start at cycle 12 completes normally at cycle 45.
- rst asserted mid-BUSY → next cycle IDLE, result=0, ready=0, stall_div=0. Back-to-back DIVU pair → second launch accepted the cycle after DONE.
